fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit RISC CPU. Owns the program counter, drives the synchronous instruction memory address, and absorbs that memory's one-cycle read latency. Captures each returned instruction with its PC in a 2-entry skid buffer and presents it to decode over a valid/ready handshake. Supports jump/branch redirect with flush of in-flight and buffered fetches.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_skid_buffer.sv | 60 ++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: datapath widths and the
// instruction opcode field layout.
package cpu_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 5;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 5;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of {instruction, pc} sitting between instruction memory
// and decode. Push and pop may happen in the same cycle; flush empties it.
module fetch_skid_buffer #(
  parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_WIDTH-1:0]    i_push_instruction,
  input  logic [ADDRESS_WIDTH-1:0] i_push_pc,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [1:0]               o_occupancy,
  output logic                     o_head_valid,
  output logic [DATA_WIDTH-1:0]    o_head_instruction,
  output logic [ADDRESS_WIDTH-1:0] o_head_pc
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instruction;
    logic [ADDRESS_WIDTH-1:0] pc;
  } entry_t;

  entry_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too (only two entries) so the head reads 0 out of reset.
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= '{instruction: i_push_instruction, pc: i_push_pc};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_occupancy        = r_count;
  assign o_head_valid       = (r_count != 2'd0);
  assign o_head_instruction = r_mem[r_rd_ptr].instruction;
  assign o_head_pc          = r_mem[r_rd_ptr].pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-cycle memory latency tracking, redirect
// flush, and the skid buffer toward decode. Optional FETCH_HALT_EN stops fetch on HLT.
module fetch_unit #(
  parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH,
  parameter int RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] im_address,
  input  logic [DATA_WIDTH-1:0]    im_instruction,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instruction,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     halted
);

  import cpu_pkg::*;

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] r_inflight_pc;
  logic                     r_inflight;

  logic [1:0] w_occupancy;
  logic [2:0] w_pending;
  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_halt_hit;
  logic       w_halted;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight & ~redirect_valid;

  // Entries that will occupy the buffer once the in-flight read lands; the
  // issue limit keeps that at most two, so a push can never overflow.
  assign w_pending = {1'b0, w_occupancy} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (w_pending < 3'd2) & ~w_halted & ~w_halt_hit & ~redirect_valid;

`ifdef FETCH_HALT_EN
  logic r_halted;

  assign w_halt_hit = r_inflight && (im_instruction[OPCODE_MSB:OPCODE_LSB] == OP_HLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_halted <= 1'b0;
    else if (redirect_valid) r_halted <= 1'b0;
    else if (w_halt_hit)     r_halted <= 1'b1;
  end

  assign w_halted = r_halted;
`else
  assign w_halt_hit = 1'b0;
  assign w_halted   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      r_pc          <= ADDRESS_WIDTH'(RESET_PC);
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_halt_hit) begin
      r_pc       <= r_inflight_pc + ADDRESS_WIDTH'(1);
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + ADDRESS_WIDTH'(1);
      r_inflight_pc <= r_pc;
      r_inflight    <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_skid_buffer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_skid (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_push            (w_push),
    .i_push_instruction(im_instruction),
    .i_push_pc         (r_inflight_pc),
    .i_pop             (w_pop),
    .i_flush           (redirect_valid),
    .o_occupancy       (w_occupancy),
    .o_head_valid      (out_valid),
    .o_head_instruction(out_instruction),
    .o_head_pc         (out_pc)
  );

  assign im_address = r_pc;
  assign halted     = w_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector tables for the
// directed scenarios, then randomized traffic against a delivery-order model.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] im_address;
  logic [7:0] im_instruction;
  logic       redirect_valid;
  logic [4:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instruction;
  logic [4:0] out_pc;
  logic       halted;

  logic [7:0] mem [32];
  int n_checks;
  int n_fail;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_address     (im_address),
    .im_instruction (im_instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) im_instruction <= mem[im_address];

  typedef struct {
    bit         first;
    bit         hlt3;
    bit         ready;
    bit         redir;
    logic [4:0] rpc;
    bit         exp_valid;
    logic [4:0] exp_pc;
    logic [7:0] exp_instr;
    bit         exp_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] f_instr(input bit hlt3, input logic [4:0] pc);
    if (hlt3 && pc == 5'd3) return 8'h00;
    return 8'h40 + {3'b000, pc};
  endfunction

  task automatic add_vec(input bit first, input bit hlt3, input bit ready, input bit redir,
                         input logic [4:0] rpc, input bit ev, input logic [4:0] epc,
                         input bit eh);
    vec_t v;
    v.first = first; v.hlt3 = hlt3; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = f_instr(hlt3, epc); v.exp_halted = eh;
    vecs.push_back(v);
  endtask

  // Called at a falling edge; leaves the DUT out of reset at the start of cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 5'd0;
    out_ready = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_pc", out_pc, 5'd0);
    check("reset_out_instruction", out_instruction, 8'h00);
    check("reset_im_address", im_address, 5'd0);
    check("reset_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic build_table();
    // Straight run with out_ready held high.
    for (int c = 0; c < 8; c++)
      add_vec(c == 0, 0, 1, 0, 5'd0, c >= 2, 5'(c - 2), 0);
    // Backpressure for cycles 3..7.
    for (int c = 0; c < 14; c++)
      add_vec(c == 0, 0, !(c >= 3 && c <= 7), 0, 5'd0, c >= 2,
              (c < 3) ? 5'(c - 2) : (c <= 7) ? 5'd1 : 5'(c - 7), 0);
    // Redirect at cycle 6 to 20 while head (pc 4) is not accepted.
    for (int c = 0; c < 12; c++)
      add_vec(c == 0, 0, c != 6, c == 6, 5'd20, (c >= 2 && c <= 6) || c >= 9,
              (c <= 6) ? 5'(c - 2) : 5'(20 + c - 9), 0);
    // Redirect and pop together at cycle 4, target 30 so the run wraps.
    for (int c = 0; c < 12; c++)
      add_vec(c == 0, 0, 1, c == 4, 5'd30, (c >= 2 && c <= 4) || c >= 7,
              (c <= 4) ? 5'(c - 2) : 5'(30 + c - 7), 0);
    // memory[3] holds HLT; redirect to 8 at cycle 9.
    for (int c = 0; c < 14; c++) begin
`ifdef FETCH_HALT_EN
      add_vec(c == 0, 1, 1, c == 9, 5'd8, (c >= 2 && c <= 5) || c >= 12,
              (c <= 5) ? 5'(c - 2) : 5'(8 + c - 12), c >= 5 && c <= 9);
`else
      add_vec(c == 0, 1, 1, c == 9, 5'd8, (c >= 2 && c <= 9) || c >= 12,
              (c <= 9) ? 5'(c - 2) : 5'(8 + c - 12), 0);
`endif
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      if (vecs[i].first) begin
        for (int a = 0; a < 32; a++) mem[a] = f_instr(vecs[i].hlt3, 5'(a));
        do_reset();
      end
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_instr", i), out_instruction, vecs[i].exp_instr);
      end
      check($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  // Reference model: instructions leave in program order from the last
  // restart point; the head is valid from the third cycle after a restart.
  task automatic run_random(input int cycles);
    logic [4:0] exp_next;
    int         since;
    bit         exp_v;
    bit         rdy;
    for (int a = 0; a < 32; a++) begin
      mem[a] = 8'($urandom);
`ifdef FETCH_HALT_EN
      if (mem[a][7:5] == 3'b000) mem[a][7:5] = 3'b001;
`endif
    end
    do_reset();
    exp_next = 5'd0;
    since    = 0;
    for (int c = 0; c < cycles; c++) begin
      exp_v = (since >= 2);
      check("rnd_valid", out_valid, exp_v);
      if (exp_v) begin
        check("rnd_pc", out_pc, exp_next);
        check("rnd_instr", out_instruction, mem[exp_next]);
      end
      check("rnd_halted", halted, 1'b0);
      rdy = ($urandom_range(0, 3) != 0);
      out_ready      = rdy;
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 5'($urandom_range(0, 31));
      if (exp_v && rdy) exp_next = exp_next + 5'd1;
      if (redirect_valid) begin
        exp_next = redirect_pc;
        since    = 0;
      end else if (since < 2) begin
        since++;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 5'd0;
    for (int a = 0; a < 32; a++) mem[a] = 8'h00;
    @(negedge clk);

    build_table();
    run_table();
    run_random(1500);

    // Reset asserted between clock edges must clear state at once.
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_pc", out_pc, 5'd0);
    check("async_reset_im_address", im_address, 5'd0);
    #20;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
